arb_rr_pkt: RTL

Round-robin, packet-locking arbiter that shares one downstream resource among `WIDTH` requesters. It reuses the combinational fixed-priority arbiter `arb_fp` as its selection core and drives `arb_fp`'s one-hot priority input from a rotating pointer. Once a requester wins, the block holds the grant until that requester's packet completes (`v_last`) or an idle-timeout fires. It sits between requester ports and a single-beat `vld`/`rdy` resource such as a shared bus or memory port.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/arb_fp.sv | 25 ++
 rtl/arb_rr_pkt.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
//   arb_state_e : two-state arbitration FSM encoding
//   rotl1       : one-hot rotate-left by one within the low w bits
//   onehot2idx  : binary index of a one-hot vector
// Helpers operate on ARB_MAX_W-bit vectors. Callers zero-extend their
// WIDTH-bit value and truncate the result back with a size cast.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int ARB_MAX_W = 32;
  localparam int ARB_IDX_W = 5;

  // Bit w-1 wraps to bit 0; bits at or above w are ignored.
  function automatic logic [ARB_MAX_W-1:0] rotl1(input logic [ARB_MAX_W-1:0] v,
                                                 input int w);
    logic [ARB_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (i < w) r[(i + 1) % w] = v[i];
    end
    return r;
  endfunction

  // OR of the indices of all set bits; exact for one-hot or zero input.
  function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_W-1:0] v);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (v[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_fp.sv
// Combinational fixed-priority arbiter with a movable priority point.
//   v_vld      in  WIDTH : request vector
//   v_priority in  WIDTH : one-hot position of highest priority
//   v_grant    out WIDTH : one-hot grant, first request at or above
//                          v_priority wrapping upward; zero if no request
module arb_fp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] v_vld,
  input  logic [WIDTH-1:0] v_priority,
  output logic [WIDTH-1:0] v_grant
);

  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_sel;

  // Doubling the request vector turns the wrap-around search into a plain
  // borrow chain: subtracting the priority bit clears every bit from the
  // priority position up to and including the first request, so the AND
  // with the inverted difference isolates exactly that request.
  assign w_dbl   = {v_vld, v_vld};
  assign w_sel   = w_dbl & ~(w_dbl - {{WIDTH{1'b0}}, v_priority});
  assign v_grant = w_sel[WIDTH-1:0] | w_sel[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/arb_rr_pkt.sv
// Round-robin, packet-locking arbiter for one shared single-beat resource.
//   clk, rst    : clock, asynchronous active-high reset
//   v_vld       : per-requester beat valid
//   v_last      : per-requester last beat of packet (qualified by v_vld)
//   rdy         : resource accepts the granted beat this cycle
//   v_grant     : registered one-hot grant, zero when idle
//   gnt_vld     : |v_grant
//   gnt_idx     : binary index of v_grant, zero when idle
//   xfer        : combinational, granted requester valid and rdy
//   err_timeout : one-cycle pulse after a grant is revoked by idle timeout
// Handshake: a beat moves on a cycle where the granted requester's v_vld
// and rdy are both high (xfer); neither side may depend on the other
// combinationally, and v_last is meaningful only on such beats.
// WIDTH must be between 2 and arb_pkg::ARB_MAX_W.
module arb_rr_pkt
  import arb_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         v_vld,
  input  logic [WIDTH-1:0]         v_last,
  input  logic                     rdy,
  output logic [WIDTH-1:0]         v_grant,
  output logic                     gnt_vld,
  output logic [$clog2(WIDTH)-1:0] gnt_idx,
  output logic                     xfer,
  output logic                     err_timeout
);

  localparam int IW = $clog2(WIDTH);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_grant;
  logic [WIDTH-1:0] w_grant_nxt;
  logic [WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0] w_ptr_nxt;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_prio;
  logic [WIDTH-1:0] w_fp_grant;
  logic             w_gnt_valid;
  logic             w_gnt_last;
  logic             w_xfer;
  logic             w_rel_last;
  logic             w_rel_to;
  logic             w_release;
  logic             w_err;

  // Pointer that takes effect on release: the slot just above the winner.
  assign w_rot = WIDTH'(rotl1(ARB_MAX_W'(r_grant), WIDTH));

  // While busy the selector only matters on release, when the rotated
  // pointer must already be in force for the same-cycle re-arbitration.
  assign w_prio = (r_state == ARB_BUSY) ? w_rot : r_ptr;

  arb_fp #(
    .WIDTH(WIDTH)
  ) u_fp (
    .v_vld     (v_vld),
    .v_priority(w_prio),
    .v_grant   (w_fp_grant)
  );

  // Masking with the grant ignores valid/last on non-granted requesters.
  assign w_gnt_valid = |(r_grant & v_vld);
  assign w_gnt_last  = |(r_grant & v_vld & v_last);
  assign w_xfer      = w_gnt_valid & rdy;
  assign w_rel_last  = (r_state == ARB_BUSY) & w_xfer & w_gnt_last;
  assign w_release   = w_rel_last | w_rel_to;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_cnt;
      logic          r_err;

      // Fires in the idle cycle that brings the count to TIMEOUT, so the
      // register itself never has to hold TIMEOUT.
      assign w_rel_to = (r_state == ARB_BUSY) && !w_gnt_valid &&
                        (r_cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if ((r_state != ARB_BUSY) || w_gnt_valid || w_release) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // A last-beat release always wins; the two cannot coincide anyway
      // because a transfer needs the granted valid high.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_err <= 1'b0;
        end else begin
          r_err <= w_rel_to & ~w_rel_last;
        end
      end

      assign w_err = r_err;
    end else begin : g_no_timeout
      assign w_rel_to = 1'b0;
      assign w_err    = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= WIDTH'(1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|v_vld) begin
          w_grant_nxt = w_fp_grant;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (w_release) begin
          // Back-to-back regrant when anyone is still requesting,
          // including the releasing requester (now lowest priority).
          w_ptr_nxt   = w_rot;
          w_grant_nxt = w_fp_grant;
          w_state_nxt = (|w_fp_grant) ? ARB_BUSY : ARB_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign v_grant     = r_grant;
  assign gnt_vld     = |r_grant;
  assign gnt_idx     = IW'(onehot2idx(ARB_MAX_W'(r_grant)));
  assign xfer        = w_xfer;
  assign err_timeout = w_err;

endmodule
